// File: rtl/mem_responder.sv
// ============================================================================
//  mem_responder
//  Fixed-latency 128-bit block memory responder with a protocol-violation flag.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module mem_responder #(
  parameter int LATENCY   = 8,
  parameter int ADDR_BITS = 8
) (
  input  logic         clk,
  input  logic         proc_reset_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [27:0]  mem_addr,
  input  logic [127:0] mem_wdata,
  output logic [127:0] mem_rdata,
  output logic         mem_ready,
  output logic         busy,
  output logic         proto_err
);

  localparam int         DEPTH    = 2 ** ADDR_BITS;
  localparam logic [7:0] CNT_LOAD = (LATENCY >= 2) ? 8'(LATENCY - 2) : 8'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   op_wr_q, op_wr_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [127:0]           wdata_q, wdata_d;
  logic                   perr_q, perr_d;
  logic [127:0]           rdata_q;
  logic [127:0]           store_q [DEPTH];
  logic                   w_enter_resp;

  // Upper address bits alias onto the decoded range and are intentionally unused.
  generate
    if (ADDR_BITS < 28) begin : g_addr_unused
      logic unused_addr_bits;
      assign unused_addr_bits = ^mem_addr[27:ADDR_BITS];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    perr_d  = perr_q;
    case (state_q)
      S_IDLE: begin
        if (mem_write || mem_read) begin
          addr_d  = mem_addr[ADDR_BITS-1:0];
          op_wr_d = mem_write;
          if (mem_write) begin
            wdata_d = mem_wdata;
          end
          if (mem_write && mem_read) begin
            perr_d = 1'b1;
          end
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        // A dropped request before completion is an abort, which wins over expiry.
        if (!mem_read && !mem_write) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
          perr_d  = 1'b1;
        end else if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next-state views are used so the LATENCY=1 path (IDLE->RESP) sees the new request.
  assign w_enter_resp = (state_d == S_RESP) && (state_q != S_RESP);

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      perr_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      perr_q  <= perr_d;
      if (w_enter_resp && !op_wr_d) begin
        rdata_q <= store_q[addr_d];
      end
    end
  end

  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        store_q[i] <= '0;
      end
    end else if (w_enter_resp && op_wr_d) begin
      store_q[addr_d] <= wdata_d;
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = (state_q == S_RESP);
  assign busy      = (state_q != S_IDLE);
  assign proto_err = perr_q;

endmodule

`default_nettype wire

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 8, cycles from request acceptance to mem_ready; legal range 1..255.
REQ-002 SHALL have parameter ADDR_BITS, default 8, number of block-address bits decoded; storage depth 2**ADDR_BITS blocks of 128 bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on posedge.
REQ-004 SHALL have port proc_reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mem_read  input  1  block read request, held by initiator until mem_ready.
REQ-006 SHALL have port mem_write  input  1  block write request, held by initiator until mem_ready.
REQ-007 SHALL have port mem_addr  input  28  block address; only bits [ADDR_BITS-1:0] decoded, upper bits ignored (aliasing).
REQ-008 SHALL have port mem_wdata  input  128  write block data.
REQ-009 SHALL have port mem_rdata  output  128  read block data, registered.
REQ-010 SHALL have port mem_ready  output  1  one-cycle completion pulse, registered.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-012 SHALL have port proto_err  output  1  sticky protocol-violation flag.

Function
REQ-013 SHALL implement FSM with states IDLE, WAIT, RESP.
REQ-014 IDLE: mem_write high -> latch addr, wdata, op=WRITE; else mem_read high -> latch addr, op=READ; neither -> stay IDLE.
REQ-015 On acceptance with LATENCY=1 SHALL go directly to RESP; otherwise SHALL load down-counter with LATENCY-2 and go to WAIT.
REQ-016 WAIT: counter nonzero -> decrement, stay; counter zero -> RESP.
REQ-017 Request accepted in cycle T SHALL produce mem_ready high exactly in cycle T+LATENCY, for exactly one cycle.
REQ-018 mem_ready SHALL equal (state==RESP); RESP SHALL always return to IDLE next cycle.
REQ-019 Read: mem_rdata SHALL be loaded from storage[latched addr] on the clock edge entering RESP and SHALL hold that value until the next read completes.
REQ-020 Write: storage[latched addr] SHALL be updated with latched wdata on the clock edge entering RESP; mem_rdata unchanged by writes.
REQ-021 mem_addr/mem_wdata changes after acceptance SHALL be ignored.
REQ-022 Request deasserted (both mem_read and mem_write low) during WAIT SHALL abort: return to IDLE next edge, no storage update, no mem_ready, proto_err set.
REQ-023 mem_read and mem_write both high in IDLE SHALL serve the write and set proto_err.
REQ-024 Request present in the cycle immediately after RESP SHALL be accepted in that cycle (one idle cycle turnaround minimum; no back-to-back ready).
REQ-025 Request levels during RESP SHALL be ignored (initiator drops request combinationally on mem_ready).
REQ-026 proto_err SHALL remain high until reset.

Reset
REQ-027 proc_reset_n low SHALL immediately, without clock, force state=IDLE, counter=0, mem_ready=0, busy=0, proto_err=0, mem_rdata=0.
REQ-028 Reset SHALL clear all storage blocks to 128'h0.
REQ-029 Reset asserted mid-transaction SHALL discard the transaction: no storage update, no mem_ready after release.
REQ-030 After proc_reset_n rises, first request SHALL be accepted on the first posedge at which it is sampled.

Verification
REQ-031 After reset, mem_read=1 addr=28'h5 (LATENCY=8) held -> mem_ready pulses 8 cycles after acceptance, mem_rdata=128'h0, busy high for 8 cycles.
REQ-032 mem_write addr=28'h12 wdata=128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, then mem_read addr=28'h12 on cycle after ready -> read ready returns same 128-bit value; write does not change mem_rdata.
REQ-033 Write addr=28'h103 data=128'h1, read addr=28'h003 (ADDR_BITS=8) -> returns 128'h1 (alias).
REQ-034 mem_read and mem_write both high addr=28'h7 wdata=128'hA5 -> write served, proto_err=1; subsequent read addr 7 returns 128'hA5.
REQ-035 Read accepted, mem_read dropped after 3 cycles -> no mem_ready, busy low next cycle, proto_err=1; write accepted then proc_reset_n pulsed low mid-WAIT -> mem_ready never asserts, storage reads back 0.
REQ-036 LATENCY=1 build: read accepted cycle T -> mem_ready at T+1; next request accepted at T+2.
